datapath_seq: RTL
=================

Name: datapath_seq

Overview:
Parametrised, self-sequencing successor to the lab datapath. It has configurable data width, register count and PC width. It accepts one register-to-register or load-immediate command per start/done handshake, and it sequences the A/B/C pipeline loads, shift, ALU, status update and writeback internally, so the controller no longer drives loada/loadb/loadc/write cycle by cycle. It sits between the CPU instruction decoder (command source) and memory/PC logic (mdata, pc inputs).

Parameters:
W, 16, data width of registers, ALU, C register and mdata/imm.
NREG, 8, number of general registers; power of two, minimum 2; AW = $clog2(NREG) is a localparam.
PCW, 8, program-counter width; PCW <= W; zero-extended to W on writeback.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  command valid; accepted only when busy=0
rn  in  AW  A-operand register
rm  in  AW  B-operand register
rd  in  AW  destination register
alu_op  in  2  00 ADD, 01 SUB (A-B), 10 AND, 11 MVN (~B)
shift  in  2  applied to B: 00 none, 01 LSL1, 10 LSR1 (fill 0), 11 ASR1 (fill msb)
a_zero  in  1  Ain forced to 0
use_imm  in  1  Bin = imm, bypasses shifter
imm  in  W  sign-extended immediate (from decoder)
wb_sel  in  2  writeback source: 00 C, 01 imm, 10 {0,pc}, 11 mdata
write_en  in  1  write Rd at end of command
set_flags  in  1  update status at EXEC
pc  in  PCW  program counter value
mdata  in  W  memory read data
dbg_addr  in  AW  combinational debug read address
dbg_data  out  W  register[dbg_addr], combinational
datapath_out  out  W  C register
flags  out  3  {V,N,Z}
busy  out  1  high from acceptance until done
done  out  1  one-cycle pulse, last cycle of command

Behaviour:
- Reset (async, any state): state IDLE; A, B, C, flags and all registers cleared to 0; busy=0, done=0; any in-flight writeback is discarded.
- Acceptance: start=1 and state IDLE at a rising edge. All command fields are latched into a command register at that edge. Later input changes are ignored until the next acceptance.
- start while busy=1 is ignored. It is not queued.
- FSM states: IDLE, LOAD_A, LOAD_B, EXEC, WB.
- ALU command (wb_sel=00): IDLE -> LOAD_A -> LOAD_B -> EXEC -> WB -> IDLE.
  - LOAD_A: A <= R[rn].
  - LOAD_B: B <= R[rm].
  - EXEC: C <= ALU(Ain, shifted or imm Bin); flags are updated here if set_flags.
  - WB: R[rd] <= C if write_en; done=1.
- Non-ALU command (wb_sel!=00): IDLE -> WB -> IDLE. R[rd] <= selected source if write_en; done=1. A, B, C and flags are unchanged.
- Latency: the ALU command has done high in the 4th cycle after the acceptance edge. A non-ALU command has done high in the 1st cycle. Back-to-back: start may be re-asserted in the done cycle; the next command is accepted on the following edge, once IDLE is reached.
- busy = (state != IDLE). done = (state == WB).
- Arithmetic is modulo 2^W.
  - Z = (result == 0). N = result[W-1].
  - V for ADD: A[msb]==B[msb] && res[msb]!=A[msb].
  - V for SUB: A[msb]!=B[msb] && res[msb]!=A[msb].
  - V for AND and MVN: 0.
- A register read in LOAD_A/LOAD_B returns the value committed by the previous command's WB, because writes complete before the next acceptance.
- rn == rm == rd is legal.
- dbg_data reflects a write on the clock edge after WB.

Decomposition:
- Package dp_pkg holds:
  - ALU op, shift and wb_sel encodings as localparams/enums.
  - FSM state typedef (IDLE, LOAD_A, LOAD_B, EXEC, WB).
  - Flag bit indices V=2, N=1, Z=0.
- Sub-module regfile_p (#W, NREG): two combinational read ports (operand and debug), one synchronous write port, asynchronous active-high clear.
- ALU and shifter are combinational blocks within datapath_seq.

Test Plan:
1. Assert reset mid-idle and mid-EXEC -> datapath_out=0, flags=000, busy=0, done=0, dbg_data=0 for all registers; no writeback occurs after reset mid-command.
2. Load imm 16'h0007->R0 and 16'h0002->R1 (wb_sel=01) -> done on 1st cycle each. Then ADD R2=R0+R1, set_flags -> done on 4th cycle, R2=16'h0009, datapath_out=16'h0009, flags=000.
3. R0=16'h7FFF, R1=16'hFFFF; SUB R3=R0-R1, set_flags -> R3=16'h8000, flags=110 (V=1, N=1, Z=0).
4. CMP form: R4=R5=16'h1234; SUB with write_en=0, set_flags=1, rd=R4 -> flags=001, R4 still 16'h1234.
5. R1=16'h8004; MOV-shift (a_zero=1, ADD, shift=11, rm=R1, rd=R6) -> R6=16'hC002. Assert start during LOAD_B with rd=R7 -> ignored: R7 unchanged, exactly one done pulse.
6. pc=8'hA5 with wb_sel=10 rd=R1 -> R1=16'h00A5. Then mdata=16'hBEEF with wb_sel=11 rd=R2 -> R2=16'hBEEF; flags unchanged across both.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared encodings for the self-sequencing datapath: ALU/shift/writeback selects,
// FSM states and status flag bit positions.
package dp_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    localparam logic [1:0] WB_C     = 2'b00;
    localparam logic [1:0] WB_IMM   = 2'b01;
    localparam logic [1:0] WB_PC    = 2'b10;
    localparam logic [1:0] WB_MDATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        EXEC,
        WB
    } state_t;

    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/regfile_p.sv
// General register file: one operand read port and one debug read port (both
// combinational), one synchronous write port, asynchronous clear.
module regfile_p #(
    parameter int  W    = 16,
    parameter int  NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  dbg_data,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data
);

    logic [W-1:0] regs_q [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data  = regs_q[rd_addr];
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/datapath_seq.sv
// Self-sequencing register datapath: accepts one command per start/done handshake
// and walks LOAD_A/LOAD_B/EXEC/WB internally (non-ALU writebacks go straight to WB).
module datapath_seq
    import dp_pkg::*;
#(
    parameter int  W    = 16,
    parameter int  NREG = 8,
    parameter int  PCW  = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [AW-1:0]  rn,
    input  logic [AW-1:0]  rm,
    input  logic [AW-1:0]  rd,
    input  logic [1:0]     alu_op,
    input  logic [1:0]     shift,
    input  logic           a_zero,
    input  logic           use_imm,
    input  logic [W-1:0]   imm,
    input  logic [1:0]     wb_sel,
    input  logic           write_en,
    input  logic           set_flags,
    input  logic [PCW-1:0] pc,
    input  logic [W-1:0]   mdata,
    input  logic [AW-1:0]  dbg_addr,
    output logic [W-1:0]   dbg_data,
    output logic [W-1:0]   datapath_out,
    output logic [2:0]     flags,
    output logic           busy,
    output logic           done
);

    state_t state_q, state_d;
    logic   accept;

    logic [AW-1:0]  rn_q, rm_q, rd_q;
    logic [1:0]     alu_op_q, shift_q, wb_sel_q;
    logic           a_zero_q, use_imm_q, write_en_q, set_flags_q;
    logic [W-1:0]   imm_q, mdata_q;
    logic [PCW-1:0] pc_q;

    logic [W-1:0] a_q, b_q, c_q;
    logic [2:0]   flags_q;

    logic [AW-1:0] rf_raddr;
    logic [W-1:0]  rf_rdata, wb_data;
    logic          rf_we;

    logic signed [W-1:0] ain, bin, alu_res;
    logic [2:0]          alu_flags;

    function automatic logic signed [W-1:0] shift_b(input logic [1:0] sh,
                                                    input logic signed [W-1:0] b);
        logic signed [W-1:0] r;
        case (sh)
            SH_LSL:  r = b <<< 1;
            SH_LSR:  r = $signed({1'b0, b[W-1:1]});
            SH_ASR:  r = b >>> 1;
            default: r = b;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] alu_status(input logic [1:0] op,
                                              input logic signed [W-1:0] a,
                                              input logic signed [W-1:0] b,
                                              input logic signed [W-1:0] res);
        logic [2:0] st;
        st = '0;
        case (op)
            ALU_ADD: st[FLAG_V] = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
            ALU_SUB: st[FLAG_V] = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
            default: st[FLAG_V] = 1'b0;
        endcase
        st[FLAG_N] = res[W-1];
        st[FLAG_Z] = (res == '0);
        return st;
    endfunction

    assign accept = start && (state_q == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (wb_sel == WB_C) ? LOAD_A : WB;
            LOAD_A:  state_d = LOAD_B;
            LOAD_B:  state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every field, including pc and mdata, is frozen at acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rn_q        <= '0;
            rm_q        <= '0;
            rd_q        <= '0;
            alu_op_q    <= '0;
            shift_q     <= '0;
            wb_sel_q    <= '0;
            a_zero_q    <= 1'b0;
            use_imm_q   <= 1'b0;
            write_en_q  <= 1'b0;
            set_flags_q <= 1'b0;
            imm_q       <= '0;
            mdata_q     <= '0;
            pc_q        <= '0;
        end else if (accept) begin
            rn_q        <= rn;
            rm_q        <= rm;
            rd_q        <= rd;
            alu_op_q    <= alu_op;
            shift_q     <= shift;
            wb_sel_q    <= wb_sel;
            a_zero_q    <= a_zero;
            use_imm_q   <= use_imm;
            write_en_q  <= write_en;
            set_flags_q <= set_flags;
            imm_q       <= imm;
            mdata_q     <= mdata;
            pc_q        <= pc;
        end
    end

    assign rf_raddr = (state_q == LOAD_A) ? rn_q : rm_q;

    always_comb begin
        ain = a_zero_q ? '0 : $signed(a_q);
        bin = use_imm_q ? $signed(imm_q) : shift_b(shift_q, $signed(b_q));
        case (alu_op_q)
            ALU_ADD: alu_res = ain + bin;
            ALU_SUB: alu_res = ain - bin;
            ALU_AND: alu_res = ain & bin;
            default: alu_res = ~bin;
        endcase
        alu_flags = alu_status(alu_op_q, ain, bin, alu_res);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            flags_q <= '0;
        end else begin
            case (state_q)
                LOAD_A: a_q <= rf_rdata;
                LOAD_B: b_q <= rf_rdata;
                EXEC: begin
                    c_q <= alu_res;
                    if (set_flags_q) flags_q <= alu_flags;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wb_data = '0;
        case (wb_sel_q)
            WB_C:    wb_data = c_q;
            WB_IMM:  wb_data = imm_q;
            WB_PC:   wb_data[PCW-1:0] = pc_q;
            default: wb_data = mdata_q;
        endcase
    end

    assign rf_we = (state_q == WB) && write_en_q;

    regfile_p #(
        .W    (W),
        .NREG (NREG)
    ) u_regfile (
        .clk      (clk),
        .rst      (reset),
        .rd_addr  (rf_raddr),
        .rd_data  (rf_rdata),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .wr_addr  (rd_q),
        .wr_data  (wb_data)
    );

    assign datapath_out = c_q;
    assign flags        = flags_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == WB);

endmodule
